uart_tx_frame_engine: RTL and testbench
=======================================

// Module: uart_tx_frame_engine
//
// PURPOSE
//   Serialises one UART frame per accepted word: start bit, 5-9 data bits LSB first,
//   optional parity bit, then 1 or 2 stop bits, driven onto txd.
//   It is the transmit end of the UART link. Its frame format and parity encoding
//   match the uart-rx state machine.
//   Sits between the host-side TX buffer (valid/ready) and the pad.
//   Bit timing comes from an external oversampling tick.
//
// PARAMETERS
//   OVERSAMPLE  16  tick_os pulses per bit period; legal range 4..32
//
// PORTS
//   clk          in   1  system clock
//   rst_n        in   1  asynchronous active-low reset
//   tick_os      in   1  oversample tick, single-cycle pulse, OVERSAMPLE ticks per bit
//   tx_data      in   9  word to send; bits above data_bits are ignored
//   tx_valid     in   1  tx_data valid
//   tx_ready     out  1  engine can accept a word (high only in IDLE)
//   data_bits    in   4  number of data bits, 5-9
//   parity_mode  in   2  0=none, 1=odd, 2=even, 3=mark
//   stop_bits    in   1  0=one stop bit, 1=two stop bits
//   txd          out  1  serial output, idle high
//   tx_busy      out  1  frame in progress (any state other than IDLE)
//   bit_count    out  4  index of the data bit currently on txd; 0 outside DATA
//   frame_done   out  1  one-cycle pulse when the final stop bit completes
//
// BEHAVIOUR
//   Reset values: txd=1, tx_ready=1, tx_busy=0, bit_count=0, frame_done=0,
//     state=IDLE, tick counter=0.
//   Reset mid-frame: txd returns to 1 at once (async). The word in flight is discarded.
//
//   Handshake:
//   - A word is accepted on the clk edge where tx_valid && tx_ready.
//   - On acceptance, the engine latches tx_data, data_bits, parity_mode and stop_bits.
//     Config changes after that edge do not affect the frame in progress.
//   - tx_valid may stay high while tx_ready=0. Nothing is accepted until the engine
//     is back in IDLE.
//   - data_bits is clamped at latch time: values <5 become 5, values >9 become 9.
//
//   States: IDLE -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE.
//   - IDLE -> START on acceptance. txd goes low on the same edge, and the tick
//     counter is cleared.
//   - Each non-IDLE state holds its bit for exactly OVERSAMPLE tick_os pulses.
//     The counter increments on each tick. The state advances on the tick where
//     the counter equals OVERSAMPLE-1; the counter then wraps to 0.
//   - DATA: txd = data[bit_count]. bit_count increments at each bit boundary.
//     Leave DATA after bit (data_bits-1): go to PARITY if parity_mode != 0,
//     otherwise go to STOP1.
//   - PARITY: txd is set by parity_mode, computed over the latched data bits only:
//       odd  = ~^data
//       even =  ^data
//       mark =  1
//   - STOP1: txd=1. Go to STOP2 if stop_bits=1; otherwise go to IDLE and assert frame_done.
//   - STOP2: txd=1. Go to IDLE and assert frame_done.
//   - frame_done is asserted on the edge entering IDLE. tx_ready rises on that same
//     edge, so a back-to-back word can be accepted on the next edge. That gives zero
//     idle bits between frames.
//   - tick_os while in IDLE is ignored.
//   - Clock cycles with no tick_os leave all state unchanged.
//   - txd is registered; no combinational path from any input to txd.
//
//   Frame length in bit periods = 1 + data_bits + (parity_mode != 0) + 1 + stop_bits.
//
// TESTING
//   1. 8N1, OVERSAMPLE=16, send 0xA5
//      -> txd bit periods: 0,1,0,1,0,0,1,0,1,1
//      -> each period is 16 ticks; frame_done once after 160 ticks.
//   2. 7 data bits, odd parity, 2 stop bits, send 0x15 (three 1s)
//      -> parity bit 0; 11 bit periods; tx_busy low only after STOP2.
//   3. 9 data bits, even parity, send 0x1FF
//      -> nine 1s then parity 1. Mark parity, 5 data bits, send 0x00
//      -> parity bit 1.
//   4. tx_valid held high with two words queued
//      -> second start bit begins immediately after frame_done
//      -> no extra idle bit; tx_ready is low throughout each frame.
//   5. Assert rst_n low during DATA bit 3
//      -> txd=1, tx_ready=1, bit_count=0 immediately.
//      -> After release, a new word transmits correctly from its start bit.
//   6. data_bits=4 and data_bits=12 at acceptance
//      -> 5 and 9 data bits sent.
//      -> Changing parity_mode mid-frame has no effect on that frame.

Source files
------------

// File: rtl/uart_tx_frame_engine.sv
// UART transmit frame engine: start bit, 5-9 data bits LSB first, optional parity,
// then 1 or 2 stop bits. Bit timing comes from an external oversample tick.
module uart_tx_frame_engine #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_os,
  input  logic [8:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [3:0] data_bits,
  input  logic [1:0] parity_mode,
  input  logic       stop_bits,
  output logic       txd,
  output logic       tx_busy,
  output logic [3:0] bit_count,
  output logic       frame_done
);

  localparam int unsigned CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [8:0]    r_data, w_data_nxt;
  logic [3:0]    r_nbits, w_nbits_nxt;
  logic [1:0]    r_pmode, w_pmode_nxt;
  logic          r_stop2, w_stop2_nxt;
  logic [3:0]    r_bitcnt, w_bitcnt_nxt;
  logic          r_txd, w_txd_nxt;
  logic          r_done, w_done_nxt;

  logic [3:0]    w_nbits_clamp;
  logic [8:0]    w_mask;
  logic [3:0]    w_bitcnt_inc;
  logic          w_parity;
  logic          w_bit_end;

  always_comb begin
    w_nbits_clamp = data_bits;
    if (data_bits < 4'd5)      w_nbits_clamp = 4'd5;
    else if (data_bits > 4'd9) w_nbits_clamp = 4'd9;
  end

  // Unused upper bits are cleared at latch time so parity only sees frame bits.
  assign w_mask       = 9'h1FF >> (4'd9 - w_nbits_clamp);
  assign w_bitcnt_inc = r_bitcnt + 4'd1;
  assign w_bit_end    = tick_os && (r_cnt == CNT_LAST);

  always_comb begin
    case (r_pmode)
      2'd1:    w_parity = ~^r_data;
      2'd2:    w_parity = ^r_data;
      default: w_parity = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_data_nxt   = r_data;
    w_nbits_nxt  = r_nbits;
    w_pmode_nxt  = r_pmode;
    w_stop2_nxt  = r_stop2;
    w_bitcnt_nxt = r_bitcnt;
    w_txd_nxt    = r_txd;
    w_done_nxt   = 1'b0;

    if (r_state == S_IDLE) begin
      if (tx_valid) begin
        w_data_nxt   = tx_data & w_mask;
        w_nbits_nxt  = w_nbits_clamp;
        w_pmode_nxt  = parity_mode;
        w_stop2_nxt  = stop_bits;
        w_state_nxt  = S_START;
        w_cnt_nxt    = '0;
        w_bitcnt_nxt = '0;
        w_txd_nxt    = 1'b0;
      end
    end else if (tick_os) begin
      w_cnt_nxt = w_bit_end ? '0 : r_cnt + CW'(1);
      if (w_bit_end) begin
        // txd is loaded with the value of the state being entered.
        case (r_state)
          S_START: begin
            w_state_nxt  = S_DATA;
            w_bitcnt_nxt = '0;
            w_txd_nxt    = r_data[0];
          end
          S_DATA: begin
            if (r_bitcnt == r_nbits - 4'd1) begin
              w_bitcnt_nxt = '0;
              if (r_pmode != 2'd0) begin
                w_state_nxt = S_PARITY;
                w_txd_nxt   = w_parity;
              end else begin
                w_state_nxt = S_STOP1;
                w_txd_nxt   = 1'b1;
              end
            end else begin
              w_bitcnt_nxt = w_bitcnt_inc;
              w_txd_nxt    = r_data[w_bitcnt_inc];
            end
          end
          S_PARITY: begin
            w_state_nxt = S_STOP1;
            w_txd_nxt   = 1'b1;
          end
          S_STOP1: begin
            w_txd_nxt = 1'b1;
            if (r_stop2) begin
              w_state_nxt = S_STOP2;
            end else begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
          default: begin
            w_state_nxt = S_IDLE;
            w_txd_nxt   = 1'b1;
            w_done_nxt  = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_data   <= '0;
      r_nbits  <= 4'd5;
      r_pmode  <= '0;
      r_stop2  <= 1'b0;
      r_bitcnt <= '0;
      r_txd    <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_data   <= w_data_nxt;
      r_nbits  <= w_nbits_nxt;
      r_pmode  <= w_pmode_nxt;
      r_stop2  <= w_stop2_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_txd    <= w_txd_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign txd        = r_txd;
  assign tx_ready   = (r_state == S_IDLE);
  assign tx_busy    = (r_state != S_IDLE);
  assign bit_count  = r_bitcnt;
  assign frame_done = r_done;

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Directed bench for uart_tx_frame_engine: table of frames with hand-computed
// bit sequences, plus back-to-back, mid-frame reset and idle-tick sequences.
module tb_uart_tx_frame_engine;

  localparam int unsigned OS = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_os;
  logic [8:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] data_bits;
  logic [1:0] parity_mode;
  logic       stop_bits;
  logic       txd;
  logic       tx_busy;
  logic [3:0] bit_count;
  logic       frame_done;

  int n_vec = 0;
  int n_bad = 0;

  uart_tx_frame_engine #(.OVERSAMPLE(OS)) dut (
    .clk(clk), .rst_n(rst_n), .tick_os(tick_os),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .data_bits(data_bits), .parity_mode(parity_mode), .stop_bits(stop_bits),
    .txd(txd), .tx_busy(tx_busy), .bit_count(bit_count), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // exp_bits: bit i is txd during bit period i (period 0 = start bit).
  typedef struct {
    logic [8:0]  data;
    logic [3:0]  nb_in;
    logic [3:0]  nb_eff;
    logic [1:0]  pm;
    logic        sb;
    logic [15:0] exp_bits;
    int          exp_len;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic t);
    tick_os = t;
    @(posedge clk);
    #1;
  endtask

  // Presents a word, lets it be accepted, then scrambles the config inputs.
  task automatic accept(input logic [8:0] d, input logic [3:0] nb, input logic [1:0] pm,
                        input logic sb, input logic keep_valid, input logic [8:0] next_d);
    tx_data     = d;
    data_bits   = nb;
    parity_mode = pm;
    stop_bits   = sb;
    tx_valid    = 1'b1;
    step(1'b0);
    chk("start_txd", {31'd0, txd}, 32'd0);
    chk("start_ready", {31'd0, tx_ready}, 32'd0);
    tx_data     = keep_valid ? next_d : ~d;
    data_bits   = (nb == 4'd9) ? 4'd5 : 4'd9;
    parity_mode = pm + 2'd1;
    stop_bits   = ~sb;
    tx_valid    = keep_valid;
  endtask

  // Runs one frame from just after acceptance until tx_busy falls.
  task automatic run_frame(input logic [3:0] nb, output logic [15:0] bits, output int len,
                           output int dones, output int rdy, output int bcbad);
    logic [3:0] exp_bc;
    bits = '0; len = 15; dones = 0; rdy = 0; bcbad = 0;
    for (int p = 0; p < 15; p++) begin
      for (int unsigned t = 0; t < OS; t++) begin
        if (t == OS / 2) begin
          bits[p] = txd;
          exp_bc  = (p >= 1 && p <= int'(nb)) ? 4'(p - 1) : 4'd0;
          if (bit_count !== exp_bc) bcbad++;
        end
        step(1'b1);
        if (frame_done) dones++;
        if (!tx_busy) begin
          if (!tx_ready) rdy++;
          len = p + 1;
          return;
        end
        if (tx_ready) rdy++;
        step(1'b0);
        if (frame_done) dones++;
        if (tx_ready) rdy++;
      end
    end
  endtask

  task automatic check_frame(input string tag, input vec_t v, input logic [15:0] bits,
                             input int len, input int dones, input int rdy, input int bcbad);
    chk({tag, "_bits"}, {16'd0, bits}, {16'd0, v.exp_bits});
    chk({tag, "_len"}, len, v.exp_len);
    chk({tag, "_done"}, dones, 1);
    chk({tag, "_ready_low"}, rdy, 0);
    chk({tag, "_bitcnt"}, bcbad, 0);
  endtask

  initial begin
    logic [15:0] bits;
    int len, dones, rdy, bcbad, guard;
    vec_t v;

    vecs[0] = '{9'h0A5, 4'd8,  4'd8, 2'd0, 1'b0, 16'b1101001010,   10};
    vecs[1] = '{9'h015, 4'd7,  4'd7, 2'd1, 1'b1, 16'b11000101010,  11};
    vecs[2] = '{9'h1FF, 4'd9,  4'd9, 2'd2, 1'b0, 16'b111111111110, 12};
    vecs[3] = '{9'h000, 4'd5,  4'd5, 2'd3, 1'b0, 16'b11000000,     8};
    vecs[4] = '{9'h1F6, 4'd4,  4'd5, 2'd0, 1'b0, 16'b1101100,      7};
    vecs[5] = '{9'h12D, 4'd12, 4'd9, 2'd2, 1'b0, 16'b111001011010, 12};
    vecs[6] = '{9'h02A, 4'd6,  4'd6, 2'd1, 1'b1, 16'b1101010100,   10};
    vecs[7] = '{9'h000, 4'd8,  4'd8, 2'd2, 1'b1, 16'b110000000000, 12};

    rst_n = 1'b0; tick_os = 1'b0; tx_data = '0; tx_valid = 1'b0;
    data_bits = 4'd8; parity_mode = 2'd0; stop_bits = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_bitcnt", {28'd0, bit_count}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;

    // Ticks while idle must not disturb anything.
    for (int i = 0; i < 40; i++) step(1'b1);
    chk("idle_txd", {31'd0, txd}, 32'd1);
    chk("idle_busy", {31'd0, tx_busy}, 32'd0);

    foreach (vecs[i]) begin
      v = vecs[i];
      accept(v.data, v.nb_in, v.pm, v.sb, 1'b0, 9'd0);
      run_frame(v.nb_eff, bits, len, dones, rdy, bcbad);
      check_frame($sformatf("vec%0d", i), v, bits, len, dones, rdy, bcbad);
      step(1'b0);
      chk($sformatf("vec%0d_done_pulse", i), {31'd0, frame_done}, 32'd0);
      chk($sformatf("vec%0d_end_txd", i), {31'd0, txd}, 32'd1);
    end

    // Back-to-back: tx_valid stays high, second word 0x0A5 follows with no idle bit.
    accept(9'h1FF, 4'd9, 2'd2, 1'b0, 1'b1, 9'h0A5);
    data_bits = 4'd8; parity_mode = 2'd0; stop_bits = 1'b0;
    run_frame(4'd9, bits, len, dones, rdy, bcbad);
    check_frame("b2b_first", vecs[2], bits, len, dones, rdy, bcbad);
    chk("b2b_ready_at_done", {31'd0, tx_ready}, 32'd1);
    step(1'b0);
    chk("b2b_start_txd", {31'd0, txd}, 32'd0);
    chk("b2b_busy", {31'd0, tx_busy}, 32'd1);
    tx_valid = 1'b0;
    parity_mode = 2'd3;
    run_frame(4'd8, bits, len, dones, rdy, bcbad);
    check_frame("b2b_second", vecs[0], bits, len, dones, rdy, bcbad);

    // Reset during DATA bit 3 of an all-zero word, then a clean frame.
    step(1'b0);
    accept(9'h000, 4'd8, 2'd0, 1'b0, 1'b0, 9'd0);
    guard = 0;
    while (bit_count != 4'd3 && guard < 400) begin
      step(1'b1);
      step(1'b0);
      guard++;
    end
    chk("rst_reach_bit3", (guard < 400) ? 32'd1 : 32'd0, 32'd1);
    step(1'b1);
    step(1'b1);
    chk("pre_rst_txd", {31'd0, txd}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_txd", {31'd0, txd}, 32'd1);
    chk("midrst_ready", {31'd0, tx_ready}, 32'd1);
    chk("midrst_bitcnt", {28'd0, bit_count}, 32'd0);
    chk("midrst_busy", {31'd0, tx_busy}, 32'd0);
    step(1'b0);
    rst_n = 1'b1;
    step(1'b1);
    v = vecs[6];
    accept(v.data, v.nb_in, v.pm, v.sb, 1'b0, 9'd0);
    run_frame(v.nb_eff, bits, len, dones, rdy, bcbad);
    check_frame("post_rst", v, bits, len, dones, rdy, bcbad);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
